// File: rtl/cw_decoder_legv8.sv
// rtl/cw_decoder_legv8.sv - LEGv8 instruction decoder producing per-state control words
//
// Purpose: accepts instructions from fetch over a valid/ready handshake, latches
// them in an instruction register, and drives the control words that the control
// unit's state mux selects between. Retires an instruction when the word selected
// by the current state has NS=0, counts retirements and flags illegal opcodes.
//
// Ports:
//   clock                        rising-edge clock
//   reset                        asynchronous active-low reset
//   instr[31:0], instr_valid     instruction from fetch and its valid
//   instr_ready                  high in IF (state 0) while the IR is empty
//   state[2:0]                   control unit's registered state, 0 = IF
//   status[4:0]                  {V,C,N,Z,zero_result}; only zero_result is used
//   ControlWord1..6              control words for states 1..6
//   illegal                      sticky illegal-opcode flag
//   instr_count[CNT_W-1:0]       retired-instruction counter (wraps)
//
// Control word layout (40 bits):
//   [39:37] 0  [36:34] NS  [33] IL  [32:31] PS  [30:29] MM  [28] RW  [27] BS
//   [26] SL  [25] MD  [24:20] FS  [19] EN_PC  [18:17] KS  [16:15] 0
//   [14:10] SA  [9:5] SB  [4:0] DA

module cw_decoder_legv8 #(
  parameter int CW_LENGTH = 40,
  parameter int CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [2:0]           state,
  input  logic [4:0]           status,
  output logic [CW_LENGTH-1:0] ControlWord1,
  output logic [CW_LENGTH-1:0] ControlWord2,
  output logic [CW_LENGTH-1:0] ControlWord3,
  output logic [CW_LENGTH-1:0] ControlWord4,
  output logic [CW_LENGTH-1:0] ControlWord5,
  output logic [CW_LENGTH-1:0] ControlWord6,
  output logic                 illegal,
  output logic [CNT_W-1:0]     instr_count
);

  typedef enum logic [2:0] {
    CLS_BUBBLE = 3'd0,
    CLS_R      = 3'd1,
    CLS_I      = 3'd2,
    CLS_LD     = 3'd3,
    CLS_ST     = 3'd4,
    CLS_B      = 3'd5,
    CLS_CBZ    = 3'd6,
    CLS_ILL    = 3'd7
  } class_t;

  // ALU function-select codes understood by the datapath.
  localparam logic [4:0] FS_AND   = 5'b00000;
  localparam logic [4:0] FS_ORR   = 5'b00100;
  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;
  localparam logic [4:0] FS_PASSB = 5'b11000;

  function automatic logic [39:0] cw_pack(
    input logic [2:0] ns,
    input logic [1:0] ps,
    input logic [1:0] mm,
    input logic       rw,
    input logic       bs,
    input logic       sl,
    input logic       md,
    input logic [4:0] fs,
    input logic       en_pc,
    input logic [1:0] ks,
    input logic [4:0] sa,
    input logic [4:0] sb,
    input logic [4:0] da
  );
    return {3'b000, ns, 1'b0, ps, mm, rw, bs, sl, md, fs, en_pc, ks, 2'b00, sa, sb, da};
  endfunction

  logic [31:0]      r_ir;
  logic             r_ir_full;
  class_t           r_class;
  logic [4:0]       r_fs;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  logic [10:0] w_op;
  class_t      w_dec_class;
  logic [4:0]  w_dec_fs;
  logic        w_accept;
  logic        w_retire;
  logic [2:0]  w_sel_ns;
  logic [4:0]  w_sa;
  logic [4:0]  w_sb;
  logic [4:0]  w_da;
  logic [39:0] w_cw1;
  logic [39:0] w_cw2;
  logic        w_unused;

  // Opcode and immediate bits of the IR are consumed by decode and the datapath,
  // not by the control words; upper status flags are not needed here.
  assign w_unused = ^{r_ir[31:21], r_ir[15:10], status[4:1]};

  assign instr_ready = (state == 3'd0) && !r_ir_full;
  assign w_accept    = instr_valid && instr_ready;

  assign w_op = instr[31:21];

  always_comb begin
    w_dec_class = CLS_ILL;
    w_dec_fs    = FS_ADD;
    if (w_op == 11'b10001011000) begin
      w_dec_class = CLS_R;
      w_dec_fs    = FS_ADD;
    end else if (w_op == 11'b11001011000) begin
      w_dec_class = CLS_R;
      w_dec_fs    = FS_SUB;
    end else if (w_op == 11'b10001010000) begin
      w_dec_class = CLS_R;
      w_dec_fs    = FS_AND;
    end else if (w_op == 11'b10101010000) begin
      w_dec_class = CLS_R;
      w_dec_fs    = FS_ORR;
    end else if (w_op[10:1] == 10'b1001000100) begin
      w_dec_class = CLS_I;
      w_dec_fs    = FS_ADD;
    end else if (w_op[10:1] == 10'b1101000100) begin
      w_dec_class = CLS_I;
      w_dec_fs    = FS_SUB;
    end else if (w_op == 11'b11111000010) begin
      w_dec_class = CLS_LD;
    end else if (w_op == 11'b11111000000) begin
      w_dec_class = CLS_ST;
    end else if (w_op[10:5] == 6'b000101) begin
      w_dec_class = CLS_B;
    end else if (w_op[10:3] == 8'b10110100) begin
      w_dec_class = CLS_CBZ;
    end
  end

  // Stores and CBZ read Rt (IR[4:0]) through the B port instead of Rm.
  assign w_da = r_ir[4:0];
  assign w_sa = r_ir[9:5];
  assign w_sb = ((r_class == CLS_ST) || (r_class == CLS_CBZ)) ? r_ir[4:0] : r_ir[20:16];

  // r_class returns to BUBBLE whenever the IR empties, so it alone selects the words.
  always_comb begin
    w_cw1 = '0;
    w_cw2 = '0;
    case (r_class)
      CLS_R: begin
        w_cw1 = cw_pack(3'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, r_fs, 1'b1, 2'b00, w_sa, w_sb, w_da);
      end
      CLS_I: begin
        w_cw1 = cw_pack(3'd0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, r_fs, 1'b1, 2'b00, w_sa, w_sb, w_da);
      end
      CLS_LD: begin
        w_cw1 = cw_pack(3'd2, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, FS_ADD, 1'b0, 2'b01, w_sa, w_sb, w_da);
        w_cw2 = cw_pack(3'd0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 2'b00, w_sa, w_sb, w_da);
      end
      CLS_ST: begin
        w_cw1 = cw_pack(3'd0, 2'b01, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, FS_ADD, 1'b1, 2'b01, w_sa, w_sb, w_da);
      end
      CLS_B: begin
        w_cw1 = cw_pack(3'd0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 2'b10, w_sa, w_sb, w_da);
      end
      CLS_CBZ: begin
        // Pass Rt through the ALU to set zero_result, then branch on it next state.
        w_cw1 = cw_pack(3'd2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, FS_PASSB, 1'b0, 2'b00, w_sa, w_sb, w_da);
        w_cw2 = cw_pack(3'd0, status[0] ? 2'b10 : 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 2'b11,
                        w_sa, w_sb, w_da);
      end
      CLS_ILL: begin
        // Skip the instruction: advance PC, touch no registers.
        w_cw1 = cw_pack(3'd0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 2'b00, 5'd0, 5'd0, 5'd0);
      end
      default: begin
        w_cw1 = '0;
        w_cw2 = '0;
      end
    endcase
  end

  // Only states 1 and 2 carry decoder words; IF and states 3..7 never retire.
  always_comb begin
    w_sel_ns = 3'd1;
    if (state == 3'd1) begin
      w_sel_ns = w_cw1[36:34];
    end else if (state == 3'd2) begin
      w_sel_ns = w_cw2[36:34];
    end
  end

  assign w_retire = r_ir_full && (w_sel_ns == 3'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ir      <= '0;
      r_ir_full <= 1'b0;
      r_class   <= CLS_BUBBLE;
      r_fs      <= '0;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else if (w_accept) begin
      r_ir      <= instr;
      r_ir_full <= 1'b1;
      r_class   <= w_dec_class;
      r_fs      <= w_dec_fs;
      if (w_dec_class == CLS_ILL) begin
        r_illegal <= 1'b1;
      end
    end else if (w_retire) begin
      r_ir_full <= 1'b0;
      r_class   <= CLS_BUBBLE;
      r_count   <= r_count + CNT_W'(1);
    end
  end

  assign ControlWord1 = w_cw1;
  assign ControlWord2 = w_cw2;
  assign ControlWord3 = '0;
  assign ControlWord4 = '0;
  assign ControlWord5 = '0;
  assign ControlWord6 = '0;
  assign illegal      = r_illegal;
  assign instr_count  = r_count;

endmodule

// File: tb/tb_cw_decoder_legv8.sv
// tb/tb_cw_decoder_legv8.sv - directed self-checking bench for cw_decoder_legv8

module tb_cw_decoder_legv8;

  localparam logic [4:0] FS_ADD   = 5'b01000;
  localparam logic [4:0] FS_SUB   = 5'b01001;
  localparam logic [4:0] FS_PASSB = 5'b11000;

  logic        clock;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  state;
  logic [4:0]  status;
  logic [39:0] cw1, cw2, cw3, cw4, cw5, cw6;
  logic        illegal;
  logic [15:0] instr_count;

  int checks   = 0;
  int failures = 0;

  cw_decoder_legv8 dut (
    .clock        (clock),
    .reset        (reset),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .state        (state),
    .status       (status),
    .ControlWord1 (cw1),
    .ControlWord2 (cw2),
    .ControlWord3 (cw3),
    .ControlWord4 (cw4),
    .ControlWord5 (cw5),
    .ControlWord6 (cw6),
    .illegal      (illegal),
    .instr_count  (instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [39:0] mk(
    input logic [2:0] ns, input logic [1:0] ps, input logic [1:0] mm,
    input logic rw, input logic bs, input logic sl, input logic md,
    input logic [4:0] fs, input logic en, input logic [1:0] ks,
    input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] da
  );
    return {3'b000, ns, 1'b0, ps, mm, rw, bs, sl, md, fs, en, ks, 2'b00, sa, sb, da};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic accept(input logic [31:0] word);
    state       = 3'd0;
    instr       = word;
    instr_valid = 1'b1;
    #1;
    chk("ready_before_accept", 64'(instr_ready), 64'd1);
    tick();
    instr_valid = 1'b0;
    instr       = 32'h0;
    #1;
    chk("ready_after_accept", 64'(instr_ready), 64'd0);
  endtask

  initial begin
    reset = 1'b0; state = 3'd0; status = 5'd0; instr = 32'h0; instr_valid = 1'b0;
    #1;
    chk("rst_cw1", 64'(cw1), 64'd0);
    chk("rst_count", 64'(instr_count), 64'd0);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("idle_ready", 64'(instr_ready), 64'd1);
    chk("idle_cw1_ns_en", 64'({cw1[36:34], cw1[19]}), 64'd0);
    chk("idle_cw2to6", 64'(|{cw2, cw3, cw4, cw5, cw6}), 64'd0);
    chk("idle_illegal", 64'(illegal), 64'd0);

    // ADD X0,X1,X2
    accept(32'h8B020020);
    state = 3'd1; #1;
    chk("add_cw1", 64'(cw1), 64'(mk(3'd0, 2'b01, 2'b00, 1, 0, 1, 0, FS_ADD, 1, 2'b00, 5'd1, 5'd2, 5'd0)));
    tick();
    state = 3'd0; #1;
    chk("add_count", 64'(instr_count), 64'd1);
    chk("add_ready_after", 64'(instr_ready), 64'd1);
    chk("add_cw1_bubble", 64'(cw1), 64'd0);

    // SUBI X1,X1,#1
    accept(32'hD1000421);
    state = 3'd1; #1;
    chk("subi_cw1", 64'(cw1), 64'(mk(3'd0, 2'b01, 2'b00, 1, 1, 1, 0, FS_SUB, 1, 2'b00, 5'd1, 5'd0, 5'd1)));
    tick();
    chk("subi_count", 64'(instr_count), 64'd2);

    // LDUR X1,[X2,#...], with an excursion to an unused state on the way
    accept(32'hF8408041);
    state = 3'd1; #1;
    chk("ld_cw1", 64'(cw1), 64'(mk(3'd2, 2'b00, 2'b00, 0, 1, 0, 0, FS_ADD, 0, 2'b01, 5'd2, 5'd0, 5'd1)));
    tick();
    chk("ld_count_after_s1", 64'(instr_count), 64'd2);
    state = 3'd5; tick();
    chk("ld_count_state5", 64'(instr_count), 64'd2);
    chk("ld_ready_state5", 64'(instr_ready), 64'd0);
    state = 3'd2; #1;
    chk("ld_cw2", 64'(cw2), 64'(mk(3'd0, 2'b01, 2'b01, 1, 0, 0, 1, 5'd0, 1, 2'b00, 5'd2, 5'd0, 5'd1)));
    tick();
    chk("ld_count_after_s2", 64'(instr_count), 64'd3);

    // STUR X1,[X2,#...]
    accept(32'hF8000041);
    state = 3'd1; #1;
    chk("st_cw1", 64'(cw1), 64'(mk(3'd0, 2'b01, 2'b10, 0, 1, 0, 0, FS_ADD, 1, 2'b01, 5'd2, 5'd1, 5'd1)));
    tick();
    chk("st_count", 64'(instr_count), 64'd4);

    // B #16
    accept(32'h14000010);
    state = 3'd1; #1;
    chk("b_cw1", 64'(cw1), 64'(mk(3'd0, 2'b10, 2'b00, 0, 0, 0, 0, 5'd0, 1, 2'b10, 5'd0, 5'd0, 5'd16)));
    tick();
    chk("b_count", 64'(instr_count), 64'd5);

    // CBZ X3,#2 ; the taken/not-taken choice follows status[0] combinationally
    accept(32'hB4000043);
    state = 3'd1; #1;
    chk("cbz_cw1", 64'(cw1), 64'(mk(3'd2, 2'b00, 2'b00, 0, 0, 1, 0, FS_PASSB, 0, 2'b00, 5'd2, 5'd3, 5'd3)));
    tick();
    state = 3'd2; status = 5'b00001; #1;
    chk("cbz_cw2_taken", 64'(cw2), 64'(mk(3'd0, 2'b10, 2'b00, 0, 0, 0, 0, 5'd0, 1, 2'b11, 5'd2, 5'd3, 5'd3)));
    status = 5'b11110; #1;
    chk("cbz_cw2_not_taken", 64'(cw2), 64'(mk(3'd0, 2'b01, 2'b00, 0, 0, 0, 0, 5'd0, 1, 2'b11, 5'd2, 5'd3, 5'd3)));
    tick();
    status = 5'd0;
    chk("cbz_count", 64'(instr_count), 64'd6);

    // Illegal opcode is skipped, counted, and leaves a sticky flag
    accept(32'hFFFFFFFF);
    chk("ill_flag", 64'(illegal), 64'd1);
    state = 3'd1; #1;
    chk("ill_cw1_fields", 64'({cw1[36:34], cw1[32:31], cw1[19], cw1[28], cw1[30:29]}), 64'b000_01_1_0_00);
    tick();
    chk("ill_count", 64'(instr_count), 64'd7);

    accept(32'h8B020020);
    state = 3'd1; #1;
    chk("add2_cw1", 64'(cw1), 64'(mk(3'd0, 2'b01, 2'b00, 1, 0, 1, 0, FS_ADD, 1, 2'b00, 5'd1, 5'd2, 5'd0)));
    tick();
    chk("add2_count", 64'(instr_count), 64'd8);
    chk("add2_illegal_sticky", 64'(illegal), 64'd1);

    // Reset asserted mid-instruction, away from a clock edge
    accept(32'h8B020020);
    state = 3'd1; #1;
    chk("pre_reset_cw1_nonzero", 64'(cw1 != 40'd0), 64'd1);
    #2;
    reset = 1'b0; #1;
    chk("midrst_ready", 64'(instr_ready), 64'd0);
    chk("midrst_cw1", 64'(cw1), 64'd0);
    chk("midrst_illegal", 64'(illegal), 64'd0);
    chk("midrst_count", 64'(instr_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
